// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among several requesters,
// with a single registered response slot that supports same-cycle drain and refill.
module alu_arbiter #(
   parameter int Width      = 32,
   parameter int Requesters = 2,
   parameter int IdWidth    = $clog2(Requesters)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [Requesters-1:0]        req_valid,
   output logic [Requesters-1:0]        req_ready,
   input  logic [Requesters*Width-1:0]  req_a,
   input  logic [Requesters*Width-1:0]  req_b,
   input  logic [Requesters*3-1:0]      req_op,
   input  logic [Requesters-1:0]        req_mod,
   input  logic                         hold,
   output logic [Width-1:0]             alu_a,
   output logic [Width-1:0]             alu_b,
   output logic [2:0]                   alu_op,
   output logic                         alu_mod,
   input  logic [Width-1:0]             alu_c,
   output logic                         rsp_valid,
   output logic [IdWidth-1:0]           rsp_id,
   output logic [Width-1:0]             rsp_c,
   input  logic                         rsp_ready
);

   localparam logic [IdWidth-1:0] LastIdx = IdWidth'(Requesters - 1);

   logic               rsp_valid_q, rsp_valid_d;
   logic [IdWidth-1:0] rsp_id_q, rsp_id_d;
   logic [Width-1:0]   rsp_c_q, rsp_c_d;
   logic [IdWidth-1:0] last_q, last_d;

   logic               slot_free, grant;
   logic               found_hi, found_lo;
   logic [IdWidth-1:0] idx_hi, idx_lo;
   logic [IdWidth-1:0] next_idx, gnt_idx, sel_idx;

   // Round-robin as two scans: first valid index above last_q, else lowest valid index.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int unsigned j = 0; j < Requesters; j++) begin
         if (req_valid[j]) begin
            if (!found_hi && (IdWidth'(j) > last_q)) begin
               found_hi = 1'b1;
               idx_hi   = IdWidth'(j);
            end
            if (!found_lo) begin
               found_lo = 1'b1;
               idx_lo   = IdWidth'(j);
            end
         end
      end
      next_idx  = (last_q == LastIdx) ? '0 : last_q + 1'b1;
      gnt_idx   = found_hi ? idx_hi : idx_lo;
      slot_free = !rsp_valid_q || rsp_ready;
      grant     = slot_free && !hold && found_lo && !rst;
      sel_idx   = grant ? gnt_idx : next_idx;
   end

   always_comb begin
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = '0;
      alu_mod   = 1'b0;
      req_ready = '0;
      for (int unsigned j = 0; j < Requesters; j++) begin
         if (sel_idx == IdWidth'(j)) begin
            alu_a   = req_a[j*Width +: Width];
            alu_b   = req_b[j*Width +: Width];
            alu_op  = req_op[j*3 +: 3];
            alu_mod = req_mod[j];
         end
         req_ready[j] = grant && (gnt_idx == IdWidth'(j));
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_c_d     = rsp_c_q;
      last_d      = last_q;
      if (grant) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_idx;
         rsp_c_d     = alu_c;
         last_d      = gnt_idx;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_c_q     <= '0;
         last_q      <= LastIdx;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_c_q     <= rsp_c_d;
         last_q      <= last_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter (4 requesters): directed scenarios plus random traffic, all checked
// against a transaction-level model of the response slot and round-robin pointer.
module tb_alu_arbiter;

   localparam int W  = 32;
   localparam int R  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst, hold, rsp_ready;
   logic [R-1:0]    req_valid, req_ready, req_mod;
   logic [R*W-1:0]  req_a, req_b;
   logic [R*3-1:0]  req_op;
   logic [W-1:0]    alu_a, alu_b, alu_c, rsp_c;
   logic [2:0]      alu_op;
   logic            alu_mod, rsp_valid;
   logic [IW-1:0]   rsp_id;

   always #5 clk = ~clk;

   alu_arbiter #(.Width(W), .Requesters(R), .IdWidth(IW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_mod(req_mod), .hold(hold),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mod(alu_mod), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_ready(rsp_ready)
   );

   function automatic logic [W-1:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op, logic md);
      case (op)
         3'd0:    alu_ref = md ? a - b : a + b;
         3'd1:    alu_ref = a << b[4:0];
         3'd2:    alu_ref = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
         3'd3:    alu_ref = {{(W-1){1'b0}}, a < b};
         3'd4:    alu_ref = a ^ b;
         3'd5:    alu_ref = md ? W'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    alu_ref = a | b;
         default: alu_ref = a & b;
      endcase
   endfunction

   // Shared ALU lives in the environment.
   assign alu_c = alu_ref(alu_a, alu_b, alu_op, alu_mod);

   logic [W-1:0] ta[R], tb[R];
   logic [2:0]   top[R];
   logic         tm[R], tv[R];

   logic         m_v;
   int           m_id, m_last;
   logic [W-1:0] m_c;
   int           waits[R];
   int           max_wait;
   int           total = 0;
   int           bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < R; i++) begin
         req_valid[i]       = tv[i];
         req_a[i*W +: W]    = ta[i];
         req_b[i*W +: W]    = tb[i];
         req_op[i*3 +: 3]   = top[i];
         req_mod[i]         = tm[i];
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic md,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      tv[i] = 1'b1; top[i] = op; tm[i] = md; ta[i] = a; tb[i] = b;
   endtask

   function automatic int pick();
      if (rst || hold || (m_v && !rsp_ready)) return -1;
      for (int k = 1; k <= R; k++) begin
         if (tv[(m_last + k) % R]) return (m_last + k) % R;
      end
      return -1;
   endfunction

   // One cycle: drive, check outputs against the model, clock, advance the model.
   task automatic step();
      int g;
      logic [R-1:0] exp_rdy;
      apply();
      #2;
      g = pick();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("rsp_valid", {63'b0, rsp_valid}, {63'b0, m_v});
      if (m_v) begin
         check("rsp_id", 64'(rsp_id), 64'(m_id));
         check("rsp_c", 64'(rsp_c), 64'(m_c));
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      if (rst) begin
         m_v = 1'b0; m_id = 0; m_c = '0; m_last = R - 1;
         for (int i = 0; i < R; i++) waits[i] = 0;
      end else if (g >= 0) begin
         m_c = alu_ref(ta[g], tb[g], top[g], tm[g]);
         m_id = g; m_v = 1'b1; m_last = g;
         for (int i = 0; i < R; i++) begin
            if (i == g) waits[i] = 0;
            else if (tv[i]) begin
               waits[i]++;
               if (waits[i] > max_wait) max_wait = waits[i];
            end
         end
         tv[g] = 1'b0;
      end else if (rsp_ready) begin
         m_v = 1'b0;
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < R; i++) begin
         tv[i] = 1'b0; ta[i] = '0; tb[i] = '0; top[i] = '0; tm[i] = 1'b0; waits[i] = 0;
      end
   endtask

   initial begin
      max_wait = 0;
      clear_reqs();
      rst = 1'b1; hold = 1'b0; rsp_ready = 1'b0;
      apply();
      repeat (2) @(posedge clk);
      #1;
      m_v = 1'b0; m_id = 0; m_c = '0; m_last = R - 1;
      set_req(0, 3'd0, 1'b0, 32'd1, 32'd2);
      apply();
      #1;
      check("rst_valid", {63'b0, rsp_valid}, 64'd0);
      check("rst_id", 64'(rsp_id), 64'd0);
      check("rst_c", 64'(rsp_c), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      clear_reqs();
      rst = 1'b0;

      // Two ADD requesters, back-to-back with no idle cycle
      rsp_ready = 1'b1;
      set_req(0, 3'd0, 1'b0, 32'd5, 32'd3);
      set_req(1, 3'd0, 1'b0, 32'd10, 32'd1);
      step();
      check("add0_c", 64'(rsp_c), 64'd8);
      check("add0_id", 64'(rsp_id), 64'd0);
      step();
      check("add1_c", 64'(rsp_c), 64'd11);
      check("add1_id", 64'(rsp_id), 64'd1);
      check("add1_v", {63'b0, rsp_valid}, 64'd1);
      step();

      // SUB result held under backpressure, then drained
      rsp_ready = 1'b0;
      set_req(0, 3'd0, 1'b1, 32'd3, 32'd5);
      step();
      set_req(1, 3'd0, 1'b0, 32'd7, 32'd7);
      for (int k = 0; k < 4; k++) begin
         step();
         check("sub_c", 64'(rsp_c), 64'hFFFF_FFFE);
         check("sub_id", 64'(rsp_id), 64'd0);
         check("sub_rdy", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      step();
      check("sub_next", 64'(rsp_c), 64'd14);
      step();

      // Two continuously valid requesters alternate
      for (int k = 0; k < 6; k++) begin
         set_req(0, 3'($urandom_range(7)), 1'($urandom), $urandom, $urandom);
         set_req(1, 3'($urandom_range(7)), 1'($urandom), $urandom, $urandom);
         step();
         check("rr_seq", 64'(rsp_id), 64'(k % 2));
      end
      clear_reqs();
      step();

      // hold blocks grants; release grants next cycle
      hold = 1'b1;
      set_req(0, 3'd4, 1'b0, 32'hF0, 32'h0F);
      for (int k = 0; k < 3; k++) begin
         step();
         check("hold_v", {63'b0, rsp_valid}, 64'd0);
      end
      hold = 1'b0;
      step();
      check("xor_c", 64'(rsp_c), 64'hFF);

      // Reset discards a pending response and restarts priority at 0
      rsp_ready = 1'b0;
      set_req(0, 3'd0, 1'b0, 32'd1, 32'd1);
      step();
      set_req(2, 3'd6, 1'b0, 32'h30, 32'h03);
      set_req(3, 3'd7, 1'b0, 32'hFF, 32'h0F);
      rst = 1'b1;
      set_req(0, 3'd1, 1'b0, 32'd1, 32'd4);
      step();
      check("rst_drop", {63'b0, rsp_valid}, 64'd0);
      rst = 1'b0;
      step();
      check("rst_first", 64'(rsp_id), 64'd0);
      check("sll_c", 64'(rsp_c), 64'd16);
      clear_reqs();
      rsp_ready = 1'b1;
      step();

      // last_grant=1 with 4'b1010 -> 3 then 1
      set_req(1, 3'd0, 1'b0, 32'd2, 32'd2);
      step();
      set_req(1, 3'd5, 1'b1, 32'h8000_0000, 32'd4);
      set_req(3, 3'd3, 1'b0, 32'd1, 32'd2);
      step();
      check("rr4_a", 64'(rsp_id), 64'd3);
      step();
      check("rr4_b", 64'(rsp_id), 64'd1);
      check("sra_c", 64'(rsp_c), 64'hF800_0000);
      clear_reqs();
      step();

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         rsp_ready = ($urandom_range(3) != 0);
         hold      = ($urandom_range(7) == 0);
         rst       = ($urandom_range(99) == 0);
         for (int i = 0; i < R; i++) begin
            if (!tv[i] && $urandom_range(2) == 0)
               set_req(i, 3'($urandom_range(7)), 1'($urandom),
                       $urandom, ($urandom_range(1) != 0) ? 32'($urandom_range(40)) : $urandom);
         end
         step();
      end
      rst = 1'b0;
      check("starve", 64'(max_wait < R), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter Width, default 32, operand and result width in bits.
REQ-002 Parameter Requesters, default 2, number of requester ports; legal range 2..8.
REQ-003 Parameter IdWidth, default $clog2(Requesters), width of the grant/response ID.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  Requesters  per-requester operation request.
REQ-007 req_ready  out  Requesters  per-requester accept; one-hot or zero.
REQ-008 req_a  in  Requesters x Width  operand A per requester.
REQ-009 req_b  in  Requesters x Width  operand B per requester.
REQ-010 req_op  in  Requesters x 3  funct3 opcode per requester.
REQ-011 req_mod  in  Requesters  modifier bit per requester (SUB/SRA select).
REQ-012 hold  in  1  when high, no new grants issue.
REQ-013 alu_a, alu_b  out  Width each  operands to the shared ALU.
REQ-014 alu_op  out  3  funct3 to the shared ALU.
REQ-015 alu_mod  out  1  modifier to the shared ALU.
REQ-016 alu_c  in  Width  combinational result from the shared ALU.
REQ-017 rsp_valid  out  1  registered result available.
REQ-018 rsp_id  out  IdWidth  index of the requester that owns the result.
REQ-019 rsp_c  out  Width  registered result.
REQ-020 rsp_ready  in  1  consumer accepts the result.

Function
REQ-021 Slot free when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1 in the same cycle (pass-through).
REQ-022 Grant occurs in a cycle iff the slot is free, hold=0 and at least one req_valid bit is set.
REQ-023 Round-robin: search starts at index last_grant+1 (mod Requesters), ascending with wrap; first valid index wins.
REQ-024 req_ready SHALL be high only for the granted index, combinationally in the grant cycle; zero otherwise.
REQ-025 alu_a/alu_b/alu_op/alu_mod SHALL mux the granted requester's fields in the grant cycle; with no grant they mux the index last_grant+1 (mod Requesters), no functional meaning.
REQ-026 On grant, rsp_c<=alu_c, rsp_id<=granted index, rsp_valid<=1, last_grant<=granted index; latency one cycle from grant to rsp_valid.
REQ-027 rsp_valid=1 with rsp_ready=0: rsp_c and rsp_id hold stable, all req_ready=0.
REQ-028 rsp_ready=1 with no grant in the same cycle: rsp_valid<=0.
REQ-029 rsp_ready=1 with a new grant in the same cycle: rsp_valid stays 1, new result replaces old, no bubble.
REQ-030 hold=1 blocks grants only; an existing response still drains on rsp_ready.
REQ-031 A requester SHALL keep req_valid and its fields stable until req_ready; the block does not register request fields.
REQ-032 No starvation: a continuously valid requester is granted within Requesters grant opportunities.
REQ-033 rsp_ready while rsp_valid=0 is ignored.

Reset
REQ-034 On rst=1 at a clock edge: rsp_valid<=0, rsp_id<=0, rsp_c<=0, last_grant<=Requesters-1 (so index 0 has first priority).
REQ-035 rst=1 has priority over grant and drain in the same cycle; a pending response is discarded.
REQ-036 While rst=1, req_ready SHALL be all zero.

Verification
REQ-037 After reset, req_valid=2'b11, both ADD, a0=5,b0=3,a1=10,b1=1, rsp_ready=1 -> cycle0 grant 0, rsp_c=8 id=0; cycle1 grant 1, rsp_c=11 id=1; no idle cycle.
REQ-038 req 0 only, op SUB (000, mod=1), a=3,b=5, rsp_ready=0 for 4 cycles -> rsp_c=32'hFFFFFFFE, id=0 held stable, req_ready=0 throughout, then drains on rsp_ready.
REQ-039 Both requesters continuously valid, rsp_ready=1 for 6 cycles -> grant sequence 0,1,0,1,0,1.
REQ-040 hold=1, req_valid=2'b01 -> no req_ready, rsp_valid stays 0; hold falls -> grant next cycle, XOR a=F0,b=0F gives rsp_c=FF.
REQ-041 rsp_valid=1 pending, req pending, rst=1 one cycle -> rsp_valid=0, req_ready=0 that cycle; next cycle grant goes to index 0.
REQ-042 Requesters=4, req_valid=4'b1010 with last_grant=1 -> grant 3 then grant 1.
